hazard_scoreboard: RTL

Parametrised successor to the fixed load-use hazard detector. It tracks pending register writes from in-flight instructions that have variable result latency (ALU, load, multi-cycle mul/div). It raises RAW and WAW stalls to the IF/ID pipeline, squashes young entries on branch flush, and counts stall cycles. It sits beside ID: ID presents decoded operands each cycle, and writeback retires entries.

---
 rtl/hazard_scoreboard_pkg.sv | 13 +
 rtl/sb_entry.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 76 +++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared register-file geometry and nominal result latencies for the
// pending-write scoreboard.
package hazard_scoreboard_pkg;

  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;
  localparam int LAT_DIV  = 15;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: pending flag, bypass countdown and saturating age,
// updated with issue > flush > writeback > idle-countdown priority.
module sb_entry #(
  parameter int CNT_W     = 4,
  parameter int AGE_W     = 3,
  parameter int FLUSH_AGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [CNT_W-1:0] lat,
  input  logic             flush,
  input  logic             wb,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  // One extra bit so a limit of 2**AGE_W still flushes saturated entries.
  localparam logic [AGE_W:0] FLUSH_LIM = (AGE_W+1)'(FLUSH_AGE);

  logic [AGE_W-1:0] age;
  logic             flush_hit;
  logic             wb_hit;

  assign flush_hit = flush & busy & ({1'b0, age} < FLUSH_LIM);
  assign wb_hit    = wb & busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      age  <= '0;
    end else if (set) begin
      busy <= 1'b1;
      cnt  <= lat;
      age  <= '0;
    end else if (flush_hit || wb_hit) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (age != '1) age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Variable-latency pending-write scoreboard beside ID: RAW/WAW stall
// generation, flush squash of young entries, and stall-cycle counting.
module hazard_scoreboard #(
  parameter int NREGS     = hazard_scoreboard_pkg::NREGS,
  parameter int REG_AW    = hazard_scoreboard_pkg::REG_AW,
  parameter int CNT_W     = 4,
  parameter int AGE_W     = 3,
  parameter int FLUSH_AGE = 0,
  parameter int PERF_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_en,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_en,
  input  logic [CNT_W-1:0]  id_lat,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic              stall_raw,
  output logic              stall_waw,
  output logic              issue,
  output logic [NREGS-1:0]  busy_vec,
  output logic [31:0]       stall_cycles
);

  logic [CNT_W-1:0] cnt [NREGS];
  logic             rs1_pend;
  logic             rs2_pend;

  assign busy_vec[0] = 1'b0;
  assign cnt[0]      = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_entry
    sb_entry #(
      .CNT_W    (CNT_W),
      .AGE_W    (AGE_W),
      .FLUSH_AGE(FLUSH_AGE)
    ) u_entry (
      .clk  (clk),
      .rst  (rst),
      .set  (issue & id_rd_en & (id_rd == REG_AW'(i))),
      .lat  (id_lat),
      .flush(flush),
      .wb   (wb_valid & (wb_rd == REG_AW'(i))),
      .busy (busy_vec[i]),
      .cnt  (cnt[i])
    );
  end

  // A nonzero countdown implies busy; busy with cnt==0 is bypassable.
  assign rs1_pend  = id_rs1_en & (id_rs1 != '0) & (cnt[id_rs1] != '0);
  assign rs2_pend  = id_rs2_en & (id_rs2 != '0) & (cnt[id_rs2] != '0);
  assign stall_raw = id_valid & (rs1_pend | rs2_pend);
  assign stall_waw = id_valid & id_rd_en & (id_rd != '0) & busy_vec[id_rd]
                   & (cnt[id_rd] > id_lat);
  assign stall     = stall_raw | stall_waw;
  assign issue     = id_valid & ~stall & ~flush & ~rst;

  if (PERF_EN != 0) begin : g_perf
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        stall_cycles <= '0;
      else if (id_valid && stall)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end else begin : g_noperf
    assign stall_cycles = '0;
  end

endmodule
